// File: rtl/formula_pipe_pkg.sv
// ---------------------------------------------------------------------------
// formula_pipe_pkg
//   Shared types for the pipe-aware isqrt-sum formula FSM.
//   state_t : FSM state encoding (IDLE, ISSUE, DRAIN)
//   cnt_w() : width of a counter that must hold the values 0..n inclusive
// ---------------------------------------------------------------------------
package formula_pipe_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Counters run 0..n (n itself marks "all done"), hence n+1 values.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/formula_n_isqrt_sum_pipe_fsm.sv
// ---------------------------------------------------------------------------
// formula_n_isqrt_sum_pipe_fsm
//   Computes res = sum_{i=0..N-1} isqrt(arg[i]) using one external, pipelined
//   isqrt unit. All N operands are issued on consecutive cycles; results are
//   accumulated as they come back, including while operands are still being
//   issued (short isqrt latency).
//
// Ports
//   clk, rst        clock, synchronous active-high reset (shared with isqrt)
//   arg_vld/arg_rdy input handshake; args packs arg[i] = args[i*W +: W]
//   res_vld, res    one-cycle result strobe and the (held) result value
//   isqrt_x_vld/x   operand issue to the isqrt unit
//   isqrt_y_vld/y   result return from the isqrt unit
//   state_dbg       current FSM state (debug visibility)
//
// Handshake: a set is transferred on a rising clk edge where arg_vld and
// arg_rdy are both high. arg_rdy depends only on state (high in IDLE); the
// source must hold arg_vld and args stable until the transfer happens.
// ---------------------------------------------------------------------------
module formula_n_isqrt_sum_pipe_fsm
    import formula_pipe_pkg::*;
#(
    parameter int N     = 3,
    parameter int W     = 32,
    parameter int RES_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arg_vld,
    output logic               arg_rdy,
    input  logic [N*W-1:0]     args,
    output logic               res_vld,
    output logic [RES_W-1:0]   res,
    output logic               isqrt_x_vld,
    output logic [W-1:0]       isqrt_x,
    input  logic               isqrt_y_vld,
    input  logic [W/2-1:0]     isqrt_y,
    output logic [1:0]         state_dbg
);

    localparam int CW = cnt_w(N);

    state_t             state_q;
    logic [N*W-1:0]     arg_q;
    logic [CW-1:0]      iss_cnt_q;
    logic [CW-1:0]      rcv_cnt_q;
    logic [RES_W-1:0]   acc_q;
    logic [RES_W-1:0]   acc_d;
    logic [RES_W-1:0]   res_q;
    logic               res_vld_q;

    logic               take_y;
    logic               last_y;

    // A returning result counts only while an operation is in flight and
    // fewer than N results have been collected; anything else is stray.
    assign take_y = (state_q != IDLE) && isqrt_y_vld && (rcv_cnt_q != CW'(N));
    assign last_y = take_y && (rcv_cnt_q == CW'(N - 1));

    always_comb begin
        acc_d = acc_q;
        if (take_y) begin
            acc_d = acc_q + RES_W'(isqrt_y);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            arg_q     <= '0;
            iss_cnt_q <= '0;
            rcv_cnt_q <= '0;
            acc_q     <= '0;
            res_q     <= '0;
            res_vld_q <= 1'b0;
        end else begin
            res_vld_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (arg_vld) begin
                        arg_q     <= args;
                        acc_q     <= '0;
                        iss_cnt_q <= '0;
                        rcv_cnt_q <= '0;
                        state_q   <= ISSUE;
                    end
                end
                default: begin
                    // ISSUE and DRAIN both accumulate; ISSUE also advances
                    // the operand pointer.
                    acc_q <= acc_d;
                    if (take_y) begin
                        rcv_cnt_q <= rcv_cnt_q + 1'b1;
                    end
                    if (state_q == ISSUE) begin
                        iss_cnt_q <= iss_cnt_q + 1'b1;
                        if (iss_cnt_q == CW'(N - 1)) begin
                            state_q <= DRAIN;
                        end
                    end
                    // Final result wins over the ISSUE->DRAIN move, which
                    // only matters for a zero-latency isqrt.
                    if (last_y) begin
                        state_q   <= IDLE;
                        res_q     <= acc_d;
                        res_vld_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign arg_rdy     = (state_q == IDLE);
    assign isqrt_x_vld = (state_q == ISSUE);
    assign isqrt_x     = (state_q == ISSUE) ? arg_q[int'(iss_cnt_q)*W +: W] : '0;
    assign res_vld     = res_vld_q;
    assign res         = res_q;
    assign state_dbg   = state_q;

endmodule
